// File: rtl/hdmi_frame_capture.sv
// hdmi_frame_capture: checks incoming HDMI frame geometry against the configured
// resolution, locks after LOCK_FRAMES consecutive good frames, and then emits a
// qualified pixel stream with X/Y coordinates and frame/line markers.
// Optional statistics counters (FRAME_COUNT, ERR_COUNT) are built when the
// macro HDMI_CAPTURE_STATS_EN is defined.
module hdmi_frame_capture #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int LOCK_FRAMES = 2,
    parameter int VSYNC_POL   = 1
) (
    input  logic                        PIXCLK,
    input  logic                        RESET,
    input  logic [23:0]                 HDMI_RGB,
    input  logic                        HDMI_DE,
    input  logic                        HDMI_VSYNC,
    output logic [23:0]                 PIX_DATA,
    output logic                        PIX_VALID,
    output logic [$clog2(H_ACTIVE)-1:0] PIX_X,
    output logic [$clog2(V_ACTIVE)-1:0] PIX_Y,
    output logic                        FRAME_START,
    output logic                        LINE_END,
    output logic                        LOCKED,
    output logic                        FRAME_ERR
`ifdef HDMI_CAPTURE_STATS_EN
    ,
    output logic [15:0]                 FRAME_COUNT,
    output logic [7:0]                  ERR_COUNT
`endif
);

    localparam int XW  = $clog2(H_ACTIVE);
    localparam int YW  = $clog2(V_ACTIVE);
    localparam int PCW = $clog2(H_ACTIVE + 2);
    localparam int LCW = $clog2(V_ACTIVE + 2);
    localparam int GCW = $clog2(LOCK_FRAMES + 1);

    typedef enum logic [1:0] {
        ST_UNLOCKED,
        ST_MEASURE,
        ST_LOCKED
    } state_t;

    logic [23:0]    rgb_s1_q, rgb_s1_d;
    logic           de_s1_q, de_s1_d, de_s2_q, de_s2_d;
    logic           vs_s1_q, vs_s1_d, vs_s2_q, vs_s2_d;
    state_t         state_q, state_d;
    logic [GCW-1:0] good_cnt_q, good_cnt_d;
    logic [PCW-1:0] pix_cnt_q, pix_cnt_d;
    logic [LCW-1:0] line_cnt_q, line_cnt_d;
    logic           line_bad_q, line_bad_d;
    logic [23:0]    pix_data_q, pix_data_d;
    logic           pix_valid_q, pix_valid_d;
    logic [XW-1:0]  pix_x_q, pix_x_d;
    logic [YW-1:0]  pix_y_q, pix_y_d;
    logic           frame_start_q, frame_start_d;
    logic           line_end_q, line_end_d;
    logic           frame_err_q, frame_err_d;
    logic           de_fall, vs_lead, frame_good;

    // Input stage: two register stages; edges are found between s1 and s2.
    always_ff @(posedge PIXCLK) begin
        if (RESET) begin
            rgb_s1_q <= '0;
            de_s1_q  <= 1'b0;
            de_s2_q  <= 1'b0;
            vs_s1_q  <= 1'b0;
            vs_s2_q  <= 1'b0;
        end else begin
            rgb_s1_q <= rgb_s1_d;
            de_s1_q  <= de_s1_d;
            de_s2_q  <= de_s2_d;
            vs_s1_q  <= vs_s1_d;
            vs_s2_q  <= vs_s2_d;
        end
    end

    // Lock state, geometry counters and registered pixel outputs.
    always_ff @(posedge PIXCLK) begin
        if (RESET) begin
            state_q       <= ST_UNLOCKED;
            good_cnt_q    <= '0;
            pix_cnt_q     <= '0;
            line_cnt_q    <= '0;
            line_bad_q    <= 1'b0;
            pix_data_q    <= '0;
            pix_valid_q   <= 1'b0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            frame_start_q <= 1'b0;
            line_end_q    <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            good_cnt_q    <= good_cnt_d;
            pix_cnt_q     <= pix_cnt_d;
            line_cnt_q    <= line_cnt_d;
            line_bad_q    <= line_bad_d;
            pix_data_q    <= pix_data_d;
            pix_valid_q   <= pix_valid_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            frame_start_q <= frame_start_d;
            line_end_q    <= line_end_d;
            frame_err_q   <= frame_err_d;
        end
    end

    // Next-state: line/frame accounting, lock FSM and pixel qualification.
    always_comb begin
        rgb_s1_d   = HDMI_RGB;
        de_s1_d    = HDMI_DE;
        vs_s1_d    = HDMI_VSYNC;
        de_s2_d    = de_s1_q;
        vs_s2_d    = vs_s1_q;
        state_d    = state_q;
        good_cnt_d = good_cnt_q;
        pix_cnt_d  = pix_cnt_q;
        line_cnt_d = line_cnt_q;
        line_bad_d = line_bad_q;
        frame_err_d = 1'b0;

        de_fall = !de_s1_q && de_s2_q;
        vs_lead = (VSYNC_POL != 0) ? (vs_s1_q && !vs_s2_q) : (!vs_s1_q && vs_s2_q);

        pix_data_d    = rgb_s1_q;
        pix_x_d       = pix_cnt_q[XW-1:0];
        pix_y_d       = line_cnt_q[YW-1:0];
        pix_valid_d   = de_s1_q && (state_q == ST_LOCKED) &&
                        (pix_cnt_q < PCW'(H_ACTIVE)) && (line_cnt_q < LCW'(V_ACTIVE));
        frame_start_d = pix_valid_d && (pix_cnt_q == '0) && (line_cnt_q == '0);
        line_end_d    = pix_valid_d && (pix_cnt_q == PCW'(H_ACTIVE - 1));

        if (de_s1_q) begin
            if (pix_cnt_q != PCW'(H_ACTIVE + 1)) begin
                pix_cnt_d = pix_cnt_q + 1'b1;
            end
        end else if (de_fall) begin
            if (pix_cnt_q != PCW'(H_ACTIVE)) begin
                line_bad_d = 1'b1;
            end
            if (line_cnt_q != LCW'(V_ACTIVE + 1)) begin
                line_cnt_d = line_cnt_q + 1'b1;
            end
            pix_cnt_d = '0;
        end

        // A line ending on the same cycle as the VSYNC edge is already folded in here.
        frame_good = (line_cnt_d == LCW'(V_ACTIVE)) && !line_bad_d && !de_s1_q;

        if (vs_lead) begin
            pix_cnt_d  = '0;
            line_cnt_d = '0;
            line_bad_d = 1'b0;
            case (state_q)
                ST_UNLOCKED: begin
                    state_d    = ST_MEASURE;
                    good_cnt_d = '0;
                end
                ST_MEASURE: begin
                    if (frame_good) begin
                        good_cnt_d = good_cnt_q + 1'b1;
                        if (good_cnt_q + 1'b1 == GCW'(LOCK_FRAMES)) begin
                            state_d = ST_LOCKED;
                        end
                    end else begin
                        good_cnt_d = '0;
                    end
                end
                ST_LOCKED: begin
                    if (!frame_good) begin
                        frame_err_d = 1'b1;
                        good_cnt_d  = '0;
                        state_d     = ST_MEASURE;
                    end
                end
                default: state_d = ST_UNLOCKED;
            endcase
        end
    end

    assign PIX_DATA    = pix_data_q;
    assign PIX_VALID   = pix_valid_q;
    assign PIX_X       = pix_x_q;
    assign PIX_Y       = pix_y_q;
    assign FRAME_START = frame_start_q;
    assign LINE_END    = line_end_q;
    assign LOCKED      = (state_q == ST_LOCKED);
    assign FRAME_ERR   = frame_err_q;

`ifdef HDMI_CAPTURE_STATS_EN
    logic [15:0] frame_count_q, frame_count_d;
    logic [7:0]  err_count_q, err_count_d;

    // Statistics next-state: good locked frames (wrapping) and frame errors (saturating).
    always_comb begin
        frame_count_d = frame_count_q;
        err_count_d   = err_count_q;
        if (vs_lead && (state_q == ST_LOCKED) && frame_good) begin
            frame_count_d = frame_count_q + 1'b1;
        end
        if (frame_err_d && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 1'b1;
        end
    end

    // Statistics registers.
    always_ff @(posedge PIXCLK) begin
        if (RESET) begin
            frame_count_q <= '0;
            err_count_q   <= '0;
        end else begin
            frame_count_q <= frame_count_d;
            err_count_q   <= err_count_d;
        end
    end

    assign FRAME_COUNT = frame_count_q;
    assign ERR_COUNT   = err_count_q;
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_hdmi_frame_capture.sv
// tb_hdmi_frame_capture: directed bench for hdmi_frame_capture with an 8x4
// geometry. Statistics checks are included when HDMI_CAPTURE_STATS_EN is defined.
module tb_hdmi_frame_capture;

    localparam int H = 8;
    localparam int V = 4;

    logic        PIXCLK = 1'b0;
    logic        RESET;
    logic [23:0] HDMI_RGB;
    logic        HDMI_DE;
    logic        HDMI_VSYNC;
    logic [23:0] PIX_DATA;
    logic        PIX_VALID;
    logic [2:0]  PIX_X;
    logic [1:0]  PIX_Y;
    logic        FRAME_START;
    logic        LINE_END;
    logic        LOCKED;
    logic        FRAME_ERR;
`ifdef HDMI_CAPTURE_STATS_EN
    logic [15:0] FRAME_COUNT;
    logic [7:0]  ERR_COUNT;
`endif

    hdmi_frame_capture #(
        .H_ACTIVE    (H),
        .V_ACTIVE    (V),
        .LOCK_FRAMES (2),
        .VSYNC_POL   (1)
    ) dut (
        .PIXCLK      (PIXCLK),
        .RESET       (RESET),
        .HDMI_RGB    (HDMI_RGB),
        .HDMI_DE     (HDMI_DE),
        .HDMI_VSYNC  (HDMI_VSYNC),
        .PIX_DATA    (PIX_DATA),
        .PIX_VALID   (PIX_VALID),
        .PIX_X       (PIX_X),
        .PIX_Y       (PIX_Y),
        .FRAME_START (FRAME_START),
        .LINE_END    (LINE_END),
        .LOCKED      (LOCKED),
        .FRAME_ERR   (FRAME_ERR)
`ifdef HDMI_CAPTURE_STATS_EN
        ,
        .FRAME_COUNT (FRAME_COUNT),
        .ERR_COUNT   (ERR_COUNT)
`endif
    );

    always #5 PIXCLK = ~PIXCLK;

    int n_cmp = 0;
    int n_err = 0;

    // Output monitor: counts markers and checks raster order / ramp data of valid pixels.
    logic mon_clr = 1'b1;
    int   m_valid, m_fs, m_le, m_fe, m_coord, m_data, m_fs_bad, m_le_bad, m_idx;

    always @(negedge PIXCLK) begin
        if (mon_clr) begin
            m_valid  <= 0;
            m_fs     <= 0;
            m_le     <= 0;
            m_fe     <= 0;
            m_coord  <= 0;
            m_data   <= 0;
            m_fs_bad <= 0;
            m_le_bad <= 0;
            m_idx    <= 0;
        end else begin
            if (PIX_VALID) begin
                m_valid <= m_valid + 1;
                if (PIX_X !== 3'(m_idx % H) || PIX_Y !== 2'(m_idx / H)) m_coord <= m_coord + 1;
                if (PIX_DATA !== 24'(m_idx)) m_data <= m_data + 1;
                m_idx <= m_idx + 1;
            end
            if (FRAME_START) begin
                m_fs <= m_fs + 1;
                if (!(PIX_VALID && PIX_X == 3'd0 && PIX_Y == 2'd0)) m_fs_bad <= m_fs_bad + 1;
            end
            if (LINE_END) begin
                m_le <= m_le + 1;
                if (!(PIX_VALID && PIX_X == 3'd7)) m_le_bad <= m_le_bad + 1;
            end
            if (FRAME_ERR) m_fe <= m_fe + 1;
        end
    end

    logic lk_mid, lk_end, fe_end, fe_next;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge PIXCLK);
        #1;
    endtask

    task automatic mclear();
        mon_clr = 1'b1;
        tick();
        mon_clr = 1'b0;
    endtask

    // VSYNC pulse; captures LOCKED/FRAME_ERR one and two cycles after the rising edge.
    task automatic vs_pulse();
        HDMI_VSYNC = 1'b1;
        tick();
        lk_mid = LOCKED;
        tick();
        lk_end = LOCKED;
        fe_end = FRAME_ERR;
        HDMI_VSYNC = 1'b0;
        tick();
        fe_next = FRAME_ERR;
        tick();
    endtask

    // Active lines carrying a ramp of line*H+col; long_line gets 9 pixels.
    task automatic lines(input int nl, input int long_line, input int chk_lat);
        for (int l = 0; l < nl; l++) begin
            int len;
            len = (l == long_line) ? 9 : 8;
            for (int c = 0; c < len; c++) begin
                HDMI_DE  = 1'b1;
                HDMI_RGB = 24'(l * H + c);
                tick();
                if (chk_lat != 0 && l == 0) begin
                    if (c == 0) chk("lat_valid_early", PIX_VALID, 0);
                    if (c == 1) begin
                        chk("lat_valid_pix0", PIX_VALID, 1);
                        chk("lat_fs_pix0", FRAME_START, 1);
                        chk("lat_data_pix0", PIX_DATA, 0);
                    end
                    if (c == 2) begin
                        chk("lat_data_pix1", PIX_DATA, 1);
                        chk("lat_x_pix1", PIX_X, 1);
                    end
                end
            end
            HDMI_DE  = 1'b0;
            HDMI_RGB = '0;
            tick();
            tick();
            tick();
        end
    endtask

    initial begin
        RESET      = 1'b1;
        HDMI_RGB   = 24'hABCDEF;
        HDMI_DE    = 1'b1;
        HDMI_VSYNC = 1'b0;
        tick();
        tick();
        tick();
        chk("rst_pix_data", PIX_DATA, 0);
        chk("rst_pix_valid", PIX_VALID, 0);
        chk("rst_pix_x", PIX_X, 0);
        chk("rst_pix_y", PIX_Y, 0);
        chk("rst_frame_start", FRAME_START, 0);
        chk("rst_line_end", LINE_END, 0);
        chk("rst_locked", LOCKED, 0);
        chk("rst_frame_err", FRAME_ERR, 0);
`ifdef HDMI_CAPTURE_STATS_EN
        chk("rst_frame_count", FRAME_COUNT, 0);
        chk("rst_err_count", ERR_COUNT, 0);
`endif
        HDMI_DE  = 1'b0;
        HDMI_RGB = '0;
        tick();
        RESET = 1'b0;
        tick();
        tick();

        // Acquire lock on three clean frames.
        mclear();
        vs_pulse();
        chk("acq_vs1_locked", lk_end, 0);
        lines(4, -1, 0);
        vs_pulse();
        chk("acq_vs2_locked", lk_end, 0);
        lines(4, -1, 0);
        chk("acq_no_valid_f1f2", m_valid, 0);
        vs_pulse();
        chk("acq_vs3_locked_1cyc", lk_mid, 0);
        chk("acq_vs3_locked_2cyc", lk_end, 1);
        mclear();
        lines(4, -1, 1);
        chk("f3_valid_count", m_valid, 32);
        chk("f3_coord_err", m_coord, 0);
        chk("f3_ramp_err", m_data, 0);
        chk("f3_frame_start", m_fs, 1);
        chk("f3_fs_misplaced", m_fs_bad, 0);
        chk("f3_line_end", m_le, 4);
        chk("f3_le_misplaced", m_le_bad, 0);
        vs_pulse();
        chk("f3_eval_locked", lk_end, 1);
        chk("f3_eval_no_err", fe_end, 0);

        // Frame with a 9-pixel line while locked.
        mclear();
        lines(4, 2, 0);
        chk("long_valid_count", m_valid, 32);
        chk("long_coord_err", m_coord, 0);
        chk("long_ramp_err", m_data, 0);
        chk("long_line_end", m_le, 4);
        vs_pulse();
        chk("long_frame_err", fe_end, 1);
        chk("long_err_one_cycle", fe_next, 0);
        chk("long_unlocked", lk_end, 0);
        lines(4, -1, 0);
        vs_pulse();
        chk("relock1_vs1", lk_end, 0);
        lines(4, -1, 0);
        vs_pulse();
        chk("relock1_vs2", lk_end, 1);

        // Frame with five lines while locked.
        mclear();
        lines(5, -1, 0);
        chk("tall_valid_count", m_valid, 32);
        chk("tall_coord_err", m_coord, 0);
        chk("tall_line_end", m_le, 4);
        vs_pulse();
        chk("tall_frame_err", fe_end, 1);
        chk("tall_unlocked", lk_end, 0);
        chk("tall_fe_pulses", m_fe, 1);
        lines(4, -1, 0);
        vs_pulse();
        lines(4, -1, 0);
        vs_pulse();
        chk("relock2_locked", lk_end, 1);

        // Reset in the middle of line 1 of a locked frame.
        lines(1, -1, 0);
        for (int c = 0; c < 4; c++) begin
            HDMI_DE  = 1'b1;
            HDMI_RGB = 24'(H + c);
            tick();
        end
        chk("prerst_valid", PIX_VALID, 1);
        chk("prerst_x", PIX_X, 2);
        HDMI_RGB = 24'(H + 4);
        RESET = 1'b1;
        tick();
        chk("midrst_locked", LOCKED, 0);
        chk("midrst_valid", PIX_VALID, 0);
        RESET    = 1'b0;
        HDMI_DE  = 1'b0;
        HDMI_RGB = '0;
        mclear();
        tick();
        lines(2, -1, 0);
        vs_pulse();
        chk("postrst_vs1", lk_end, 0);
        lines(4, -1, 0);
        vs_pulse();
        chk("postrst_vs2", lk_end, 0);
        lines(4, -1, 0);
        vs_pulse();
        chk("postrst_vs3", lk_end, 1);
        chk("postrst_no_valid", m_valid, 0);

        // Three good locked frames, then a bad one.
        for (int f = 0; f < 3; f++) begin
            lines(4, -1, 0);
            vs_pulse();
        end
        chk("stats_still_locked", LOCKED, 1);
        lines(5, -1, 0);
        vs_pulse();
        chk("stats_bad_err", fe_end, 1);
`ifdef HDMI_CAPTURE_STATS_EN
        chk("stats_frame_count", FRAME_COUNT, 3);
        chk("stats_err_count", ERR_COUNT, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
